alarm_sequencer: RTL and testbench



---
 rtl/alarm_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: turns the countdown timer's done level into beep bursts
// on a piezo, silenced by the acknowledge button or after MAX_BURSTS bursts.
//
// Ports:
//   clk          1 kHz system clock
//   reset        asynchronous, active-low reset
//   tick         one-cycle 10 ms time-base enable
//   timer_done   level, high while the countdown sits at 00:00
//   ack          debounced acknowledge button (level)
//   buzzer       registered square-wave tone to the piezo
//   alarm_active high while the alarm sounds (BEEP, SPACE, GAP)
//   beep_on      high while a beep sounds (LED mirror of the envelope)
//   burst_count  bursts completed in the current alarm
module alarm_sequencer #(
    parameter int TONE_HALF       = 1,
    parameter int BEEP_ON         = 20,
    parameter int BEEP_OFF        = 10,
    parameter int BEEPS_PER_BURST = 3,
    parameter int BURST_GAP       = 50,
    parameter int MAX_BURSTS      = 10,
    parameter int CTR_WIDTH       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       timer_done,
    input  logic       ack,
    output logic       buzzer,
    output logic       alarm_active,
    output logic       beep_on,
    output logic [3:0] burst_count
);

    localparam int PH_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int BI_W = (BEEPS_PER_BURST > 1) ? $clog2(BEEPS_PER_BURST) : 1;

    localparam logic [CTR_WIDTH-1:0] ON_LAST  = CTR_WIDTH'(BEEP_ON - 1);
    localparam logic [CTR_WIDTH-1:0] OFF_LAST = CTR_WIDTH'(BEEP_OFF - 1);
    localparam logic [CTR_WIDTH-1:0] GAP_LAST = CTR_WIDTH'(BURST_GAP - 1);
    localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(TONE_HALF - 1);
    localparam logic [BI_W-1:0]      IDX_LAST = BI_W'(BEEPS_PER_BURST - 1);
    localparam logic [3:0]           MAX_B    = 4'(MAX_BURSTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEEP,
        S_SPACE,
        S_GAP,
        S_SILENCED
    } state_e;

    state_e               state_q, state_d;
    logic                 done_q, done_d;
    logic                 armed_q, armed_d;
    logic [CTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [BI_W-1:0]      idx_q, idx_d;
    logic [3:0]           burst_q, burst_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic                 buzzer_q, buzzer_d;
    logic                 active_q, active_d;
    logic                 beep_q, beep_d;

    logic start;
    logic sounding;

    // armed_q blocks a timer_done that is already high out of reset from
    // looking like a fresh edge; it must be seen low once first.
    assign start    = timer_done & ~done_q & armed_q;
    assign sounding = (state_q == S_BEEP) || (state_q == S_SPACE) ||
                      (state_q == S_GAP);

    always_comb begin
        state_d = state_q;
        done_d  = timer_done;
        armed_d = armed_q | ~timer_done;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        burst_d = burst_q;

        if (sounding) begin
            // ack wins over everything, then a dropped timer_done, then ticks
            if (ack) begin
                state_d = S_SILENCED;
                cnt_d   = '0;
            end else if (!timer_done) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                burst_d = '0;
            end else if (tick) begin
                unique case (state_q)
                    S_BEEP: begin
                        if (cnt_q == ON_LAST) begin
                            cnt_d = '0;
                            if (idx_q != IDX_LAST) begin
                                idx_d   = idx_q + 1'b1;
                                state_d = S_SPACE;
                            end else begin
                                burst_d = (burst_q == MAX_B) ? burst_q :
                                          burst_q + 4'd1;
                                state_d = S_GAP;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    S_SPACE: begin
                        if (cnt_q == OFF_LAST) begin
                            cnt_d   = '0;
                            state_d = S_BEEP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_d = '0;
                            if (burst_q == MAX_B) begin
                                state_d = S_SILENCED;
                            end else begin
                                idx_d   = '0;
                                state_d = S_BEEP;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_d = '0;
                        if (ack) begin
                            state_d = S_SILENCED;
                        end else begin
                            state_d = S_BEEP;
                            idx_d   = '0;
                            burst_d = '0;
                        end
                    end
                end
                S_SILENCED: begin
                    if (!timer_done) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Tone restarts from phase 0 / low level on every entry into BEEP.
    always_comb begin
        phase_d  = '0;
        buzzer_d = 1'b0;
        if (state_d == S_BEEP && state_q == S_BEEP) begin
            if (phase_q == PH_LAST) begin
                buzzer_d = ~buzzer_q;
            end else begin
                phase_d  = phase_q + 1'b1;
                buzzer_d = buzzer_q;
            end
        end
    end

    always_comb begin
        active_d = (state_d == S_BEEP) || (state_d == S_SPACE) ||
                   (state_d == S_GAP);
        beep_d   = (state_d == S_BEEP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            burst_q  <= '0;
            phase_q  <= '0;
            buzzer_q <= 1'b0;
            active_q <= 1'b0;
            beep_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            burst_q  <= burst_d;
            phase_q  <= phase_d;
            buzzer_q <= buzzer_d;
            active_q <= active_d;
            beep_q   <= beep_d;
        end
    end

    assign buzzer       = buzzer_q;
    assign alarm_active = active_q;
    assign beep_on      = beep_q;
    assign burst_count  = burst_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with default parameters.
// Edge index e counts clock edges from the alarm's start edge (e = 0).
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       timer_done;
    logic       ack;
    logic       buzzer;
    logic       alarm_active;
    logic       beep_on;
    logic [3:0] burst_count;

    int checks = 0;
    int errors = 0;
    int e      = 0;
    int tdiv   = 0;
    int rises  = 0;
    logic prev_beep = 1'b0;

    alarm_sequencer dut (
        .clk          (clk),
        .reset        (reset_n),
        .tick         (tick),
        .timer_done   (timer_done),
        .ack          (ack),
        .buzzer       (buzzer),
        .alarm_active (alarm_active),
        .beep_on      (beep_on),
        .burst_count  (burst_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One clock: tick on cycles where e % 10 == 9, sample #1 after edge.
    task automatic step();
        tick = (tdiv == 9);
        tdiv = (tdiv == 9) ? 0 : tdiv + 1;
        @(posedge clk);
        #1;
        e++;
        if (beep_on && !prev_beep) rises++;
        prev_beep = beep_on;
    endtask

    task automatic run_to(input int t);
        while (e < t) step();
    endtask

    // Drop timer_done briefly, then raise it; returns just after edge 0.
    task automatic start_alarm(input logic ack_v);
        timer_done = 1'b0;
        repeat (3) step();
        tdiv       = 0;
        e          = -1;
        rises      = 0;
        prev_beep  = beep_on;
        timer_done = 1'b1;
        ack        = ack_v;
        step();
        ack        = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        tick       = 1'b0;
        timer_done = 1'b0;
        ack        = 1'b0;
        #12;
        chk("rst_buzzer", buzzer, 0);
        chk("rst_active", alarm_active, 0);
        chk("rst_beep", beep_on, 0);
        chk("rst_burst", burst_count, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Envelope and tone of the first burst, then auto-silence
        start_alarm(1'b0);
        chk("t2_beep_e0", beep_on, 1);
        chk("t2_active_e0", alarm_active, 1);
        chk("t2_buz_e0", buzzer, 0);
        run_to(1);
        chk("t2_buz_e1", buzzer, 1);
        run_to(2);
        chk("t2_buz_e2", buzzer, 0);
        run_to(198);
        chk("t2_beep_e198", beep_on, 1);
        run_to(199);
        chk("t2_beep_e199", beep_on, 0);
        chk("t2_buz_e199", buzzer, 0);
        chk("t2_active_e199", alarm_active, 1);
        run_to(298);
        chk("t2_beep_e298", beep_on, 0);
        run_to(299);
        chk("t2_beep_e299", beep_on, 1);
        run_to(798);
        chk("t2_burst_e798", burst_count, 0);
        run_to(799);
        chk("t2_burst_e799", burst_count, 1);
        chk("t2_beep_e799", beep_on, 0);
        run_to(1298);
        chk("t2_beep_e1298", beep_on, 0);
        run_to(1299);
        chk("t2_beep_e1299", beep_on, 1);

        run_to(12499);
        chk("t3_burst_e12499", burst_count, 10);
        run_to(12998);
        chk("t3_active_e12998", alarm_active, 1);
        run_to(12999);
        chk("t3_active_e12999", alarm_active, 0);
        chk("t3_burst_e12999", burst_count, 10);
        run_to(13299);
        chk("t3_beeps", rises, 30);
        chk("t3_hold_active", alarm_active, 0);
        start_alarm(1'b0);
        chk("t3_restart_beep", beep_on, 1);
        chk("t3_restart_burst", burst_count, 0);

        // Asynchronous reset mid-beep, with timer_done left high
        run_to(5);
        chk("t1_buz_e5", buzzer, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_async_buz", buzzer, 0);
        chk("t1_async_beep", beep_on, 0);
        chk("t1_async_active", alarm_active, 0);
        step();
        step();
        reset_n = 1'b1;
        rises   = 0;
        repeat (300) step();
        chk("t1_no_start", rises, 0);
        chk("t1_idle_active", alarm_active, 0);
        start_alarm(1'b0);
        chk("t1_rearm_beep", beep_on, 1);

        // ack during the second beep of the first burst
        run_to(300);
        chk("t4_buz_e300", buzzer, 1);
        run_to(349);
        chk("t4_beep_e349", beep_on, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t4_ack_buz", buzzer, 0);
        chk("t4_ack_beep", beep_on, 0);
        chk("t4_ack_active", alarm_active, 0);
        rises = 0;
        repeat (1000) step();
        chk("t4_no_more", rises, 0);
        chk("t4_still_off", alarm_active, 0);

        // ack on the very cycle timer_done rises
        start_alarm(1'b1);
        chk("t5_beep", beep_on, 0);
        chk("t5_active", alarm_active, 0);
        rises = 0;
        repeat (300) step();
        chk("t5_no_beep", rises, 0);
        start_alarm(1'b0);
        chk("t5_next_beep", beep_on, 1);
        chk("t5_next_burst", burst_count, 0);

        // timer_done drops during the gap of burst 4
        start_alarm(1'b0);
        run_to(4999);
        chk("t6_burst4", burst_count, 4);
        chk("t6_gap_active", alarm_active, 1);
        chk("t6_gap_beep", beep_on, 0);
        timer_done = 1'b0;
        step();
        chk("t6_drop_active", alarm_active, 0);
        chk("t6_drop_burst", burst_count, 0);
        start_alarm(1'b0);
        chk("t6_re_beep", beep_on, 1);
        chk("t6_re_burst", burst_count, 0);
        run_to(199);
        chk("t6_beep1_end", beep_on, 0);
        run_to(798);
        chk("t6_burst_e798", burst_count, 0);
        run_to(799);
        chk("t6_burst_e799", burst_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
